fifo_word_serializer: RTL



---
 rtl/fifo_word_serializer_pkg.sv | 11 +
 rtl/fifo_word_serializer.sv | 74 +++++++
 2 files changed

// File: rtl/fifo_word_serializer_pkg.sv
// fifo_word_serializer_pkg: shared widths, derived chunk count and FSM states for the FIFO word serializer.
package fifo_word_serializer_pkg;
  localparam int DATA_BUS_SIZE = 32;
  localparam int OUT_WIDTH = 8;
  localparam int RD_LATENCY = 2;
  localparam int N = DATA_BUS_SIZE / OUT_WIDTH;
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT} state_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: pops one FIFO word at a time and streams it out LSB chunk first on valid/ready.
module fifo_word_serializer
  import fifo_word_serializer_pkg::*;
#(
  parameter int DATA_BUS_SIZE = fifo_word_serializer_pkg::DATA_BUS_SIZE,
  parameter int OUT_WIDTH = fifo_word_serializer_pkg::OUT_WIDTH,
  parameter int RD_LATENCY = fifo_word_serializer_pkg::RD_LATENCY,
  parameter int CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empt,
  input  logic [DATA_BUS_SIZE-1:0] fifo_data,
  output logic                     fifo_rd,
  output logic [OUT_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     word_cnt
);
  localparam int CHUNKS = DATA_BUS_SIZE / OUT_WIDTH;
  localparam int IW = idx_width(CHUNKS);
  localparam int WW = $clog2(RD_LATENCY + 1);
  state_t state_q, state_d;
  logic rd_q, rd_d, valid_q, valid_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BUS_SIZE-1:0] sh_q, sh_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic last, fire, capture;
  assign last = idx_q == IW'(CHUNKS - 1);
  assign fire = valid_q && out_ready;
  // Data is valid RD_LATENCY cycles after the rd pulse; capture when the count expires.
  assign capture = state_q == WAIT && wait_q == '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= 1'b0;
      valid_q <= 1'b0;
      wait_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      valid_q <= valid_d;
      wait_q <= wait_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (fifo_empt ? IDLE : WAIT) :
              state_q == WAIT ? (capture ? SHIFT : WAIT) :
              state_q == SHIFT ? (fire && last ? IDLE : SHIFT) : IDLE;
    rd_d = state_q == IDLE && !fifo_empt;
    wait_d = state_q == IDLE ? WW'(RD_LATENCY) : state_q == WAIT ? wait_q - WW'(1) : wait_q;
    sh_d = capture ? fifo_data : fire && !last ? sh_q >> OUT_WIDTH : sh_q;
    idx_d = capture ? '0 : fire && !last ? idx_q + IW'(1) : idx_q;
    valid_d = capture ? 1'b1 : fire && last ? 1'b0 : valid_q;
    cnt_d = fire && last ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_comb begin
    fifo_rd = rd_q;
    out_data = sh_q[OUT_WIDTH-1:0];
    out_valid = valid_q;
    out_last = valid_q && last;
    busy = state_q != IDLE;
    word_cnt = cnt_q;
  end
endmodule
